// File: rtl/obf_key_pkg.sv
// Shared definitions for the obfuscated-c17 key loader: cell encodings, FSM states, defaults.
package obf_key_pkg;

    localparam int unsigned NUM_CELLS_DEF = 5;

    localparam logic [1:0] CELL_PASS = 2'b00;
    localparam logic [1:0] CELL_INV  = 2'b01;
    localparam logic [1:0] CELL_ONE  = 2'b10;
    localparam logic [1:0] CELL_ZERO = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_e;

endpackage

// File: rtl/obf_key_shreg.sv
// Serial key capture: LSB-first shift register, saturating bit counter and running parity.
module obf_key_shreg #(
    parameter int unsigned KEY_W = 10,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_accept,
    input  logic             i_bit,
    output logic [KEY_W-1:0] o_shreg,
    output logic             o_count_full,
    output logic             o_parity_ok
);

    logic [KEY_W-1:0] r_shreg;
    logic [CNT_W-1:0] r_count;
    logic             r_acc;
    logic             w_full;

    assign w_full       = (r_count == CNT_W'(KEY_W));
    assign o_shreg      = r_shreg;
    assign o_count_full = w_full;
    assign o_parity_ok  = ~r_acc;

    // Key bits land at their own index; the parity bit only folds into the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_count <= '0;
            r_acc   <= 1'b0;
        end else if (i_clear) begin
            r_shreg <= '0;
            r_count <= '0;
            r_acc   <= 1'b0;
        end else if (i_accept) begin
            r_acc <= r_acc ^ i_bit;
            if (!w_full) begin
                for (int i = 0; i < int'(KEY_W); i++) begin
                    if (r_count == CNT_W'(i)) begin
                        r_shreg[i] <= i_bit;
                    end
                end
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/obf_key_loader.sv
// Serial camouflage-key loader with parity check and atomic commit to the key shadow register.
// Optional readback shifter enabled by defining OBF_KEY_READBACK_EN.
module obf_key_loader
    import obf_key_pkg::*;
#(
    parameter  int unsigned NUM_CELLS   = NUM_CELLS_DEF,
    localparam int unsigned KEY_W       = 2 * NUM_CELLS,
    parameter  logic [KEY_W-1:0] DEFAULT_KEY = {KEY_W{1'b1}},
    parameter  int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start_i,
    input  logic             ser_bit_i,
    input  logic             ser_valid_i,
    output logic             ser_ready_o,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
`ifdef OBF_KEY_READBACK_EN
    ,
    input  logic             rb_shift_i,
    output logic             rb_bit_o
`endif
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_clear;
    logic             w_accept;
    logic             w_commit;
    logic             w_fail;
    logic             w_err_clr;
    logic [KEY_W-1:0] w_shreg;
    logic             w_count_full;
    logic             w_parity_ok;

    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_key_valid;
    logic [KEY_W-1:0] r_key;

    obf_key_shreg #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) u_shreg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_accept     (w_accept),
        .i_bit        (ser_bit_i),
        .o_shreg      (w_shreg),
        .o_count_full (w_count_full),
        .o_parity_ok  (w_parity_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A start in LOAD restarts the frame and wins over a coincident valid bit.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_fail      = 1'b0;
        w_err_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_start_i) begin
                    w_state_nxt = LOAD;
                    w_clear     = 1'b1;
                    w_err_clr   = 1'b1;
                end
            end
            LOAD: begin
                if (load_start_i) begin
                    w_clear = 1'b1;
                end else if (ser_valid_i) begin
                    w_accept = 1'b1;
                    if (w_count_full) begin
                        w_state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                w_state_nxt = IDLE;
                if (w_parity_ok) begin
                    w_commit = 1'b1;
                end else begin
                    w_fail = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the upcoming state; key only moves on a good commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_key_valid <= 1'b0;
            r_key       <= DEFAULT_KEY;
        end else begin
            r_ready <= (w_state_nxt == LOAD);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == CHECK);
            if (w_fail) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
            if (w_commit) begin
                r_key       <= w_shreg;
                r_key_valid <= 1'b1;
            end
        end
    end

    assign ser_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign key_valid_o = r_key_valid;
    assign key_o       = r_key;

`ifdef OBF_KEY_READBACK_EN
    logic [KEY_W-1:0] r_rb;

    // Readback copy reloads on commit and rotates right only while no frame is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb <= DEFAULT_KEY;
        end else if (w_commit) begin
            r_rb <= w_shreg;
        end else if (rb_shift_i && !r_busy) begin
            r_rb <= {r_rb[0], r_rb[KEY_W-1:1]};
        end
    end

    assign rb_bit_o = r_rb[0];
`endif

endmodule

// File: tb/tb_obf_key_loader.sv
// Self-checking bench for obf_key_loader: frame-level reference model plus directed literal checks.
// Build with OBF_KEY_READBACK_EN defined to also exercise the readback shifter.
module tb_obf_key_loader;

    localparam int unsigned KEY_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_start_i = 1'b0;
    logic             ser_bit_i = 1'b0;
    logic             ser_valid_i = 1'b0;
    logic             ser_ready_o;
    logic [KEY_W-1:0] key_o;
    logic             key_valid_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
`ifdef OBF_KEY_READBACK_EN
    logic             rb_shift_i = 1'b0;
    logic             rb_bit_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    obf_key_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start_i),
        .ser_bit_i    (ser_bit_i),
        .ser_valid_i  (ser_valid_i),
        .ser_ready_o  (ser_ready_o),
        .key_o        (key_o),
        .key_valid_o  (key_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
`ifdef OBF_KEY_READBACK_EN
        ,
        .rb_shift_i   (rb_shift_i),
        .rb_bit_o     (rb_bit_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of received bits; it closes after KEY_W+1 bits.
    logic             m_bits[$];
    logic             m_open;
    logic             m_judge;
    logic [KEY_W-1:0] m_key;
    logic             m_kv;
    logic             m_err;
    logic [KEY_W-1:0] m_rb;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_bits.delete();
            m_open  = 1'b0;
            m_judge = 1'b0;
            m_key   = '1;
            m_kv    = 1'b0;
            m_err   = 1'b0;
            m_rb    = '1;
        end else begin
`ifdef OBF_KEY_READBACK_EN
            if (rb_shift_i && !(m_open || m_judge)) begin
                m_rb = {m_rb[0], m_rb[KEY_W-1:1]};
            end
`endif
            if (m_judge) begin
                logic [KEY_W-1:0] k;
                for (int i = 0; i < int'(KEY_W); i++) k[i] = m_bits[i];
                if ((($countones(k) + int'(m_bits[KEY_W])) % 2) == 0) begin
                    m_key = k;
                    m_kv  = 1'b1;
                    m_rb  = k;
                end else begin
                    m_err = 1'b1;
                end
                m_judge = 1'b0;
            end else if (m_open) begin
                if (load_start_i) begin
                    m_bits.delete();
                end else if (ser_valid_i) begin
                    m_bits.push_back(ser_bit_i);
                    if (m_bits.size() == KEY_W + 1) begin
                        m_open  = 1'b0;
                        m_judge = 1'b1;
                    end
                end
            end else if (load_start_i) begin
                m_open = 1'b1;
                m_bits.delete();
                m_err = 1'b0;
            end
        end
        #1;
        chk("ser_ready", 32'(ser_ready_o), 32'(m_open));
        chk("busy", 32'(busy_o), 32'(m_open || m_judge));
        chk("done", 32'(done_o), 32'(m_judge));
        chk("key", 32'(key_o), 32'(m_key));
        chk("key_valid", 32'(key_valid_o), 32'(m_kv));
        chk("err", 32'(err_o), 32'(m_err));
`ifdef OBF_KEY_READBACK_EN
        chk("rb_bit", 32'(rb_bit_o), 32'(m_rb[0]));
`endif
        if (done_o === 1'b1) n_done++;
    end

    bit rand_rb = 1'b0;

    task automatic drive(input logic st, input logic v, input logic b);
        load_start_i = st;
        ser_valid_i  = v;
        ser_bit_i    = b;
`ifdef OBF_KEY_READBACK_EN
        rb_shift_i   = rand_rb ? 1'($urandom_range(0, 1)) : 1'b0;
`endif
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            drive(1'b0, 1'b1, v[i]);
        end
    endtask

    task automatic frame(input logic [KEY_W-1:0] k, input logic par, input int gap_pct);
        drive(1'b1, 1'b0, 1'b0);
        send_bits({5'b0, par, k}, KEY_W + 1, gap_pct);
    endtask

    int rb_exp[10] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

    initial begin
        int d0;
        logic [KEY_W-1:0] k;
        logic par;

        repeat (3) @(negedge clk);
        chk("rst_key", 32'(key_o), 32'h3FF);
        chk("rst_kv", 32'(key_valid_o), 32'h0);
        chk("rst_ready", 32'(ser_ready_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("idle_key", 32'(key_o), 32'h3FF);

        // Good load of all-zero key: key held until the edge leaving CHECK.
        frame(10'h000, 1'b0, 0);
        chk("good_done", 32'(done_o), 32'h1);
        chk("good_key_hold", 32'(key_o), 32'h3FF);
        drive(1'b0, 1'b0, 1'b0);
        chk("good_key", 32'(key_o), 32'h000);
        chk("good_kv", 32'(key_valid_o), 32'h1);
        chk("good_err", 32'(err_o), 32'h0);
        chk("good_done_end", 32'(done_o), 32'h0);

        // Odd parity frame is rejected.
        frame(10'h155, 1'b0, 0);
        chk("bad_done", 32'(done_o), 32'h1);
        drive(1'b0, 1'b0, 1'b0);
        chk("bad_err", 32'(err_o), 32'h1);
        chk("bad_key", 32'(key_o), 32'h000);

        // Restart mid-frame with a colliding valid bit.
        d0 = n_done;
        drive(1'b1, 1'b0, 1'b0);
        send_bits(16'($urandom), 6, 0);
        drive(1'b1, 1'b1, 1'b1);
        send_bits({5'b0, 1'b0, 10'h0C3}, KEY_W + 1, 0);
        chk("restart_done", 32'(done_o), 32'h1);
        drive(1'b0, 1'b0, 1'b0);
        chk("restart_key", 32'(key_o), 32'h0C3);
        chk("restart_err", 32'(err_o), 32'h0);
        chk("restart_ndone", 32'(n_done - d0), 32'h1);

        // Backpressure gaps.
        frame(10'h201, 1'b0, 40);
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_key", 32'(key_o), 32'h201);

`ifdef OBF_KEY_READBACK_EN
        frame(10'h2A5, 1'b1, 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("rb_key", 32'(key_o), 32'h2A5);
        for (int i = 0; i < 10; i++) begin
            chk("rb_seq", 32'(rb_bit_o), 32'(rb_exp[i]));
            rb_shift_i = 1'b1;
            @(negedge clk);
            rb_shift_i = 1'b0;
        end
        chk("rb_wrap", 32'(rb_bit_o), 32'h1);
        rand_rb = 1'b1;
`endif

        // Randomized frames: gaps, bad parity, restarts, starts during CHECK, stray valids.
        repeat (40) begin
            k   = KEY_W'($urandom);
            par = ^k ^ ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) begin
                drive(1'b1, 1'b0, 1'b0);
                send_bits(16'($urandom), int'($urandom_range(1, 10)), 30);
                drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                send_bits({5'b0, par, k}, KEY_W + 1, 30);
            end else begin
                frame(k, par, 30);
            end
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat (int'($urandom_range(0, 3))) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-frame.
        drive(1'b1, 1'b0, 1'b0);
        send_bits(16'($urandom), 4, 0);
        load_start_i = 1'b0;
        ser_valid_i  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_key", 32'(key_o), 32'h3FF);
        chk("arst_kv", 32'(key_valid_o), 32'h0);
        chk("arst_busy", 32'(busy_o), 32'h0);
        chk("arst_ready", 32'(ser_ready_o), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
